chan_sequencer: RTL

Step sequencer that drives the four synth voices (two pulse, one triangle, one noise) feeding the 4-channel mixer. It holds a writable pattern of per-step, per-channel periods and plays it back at a programmable tempo. Each step it presents a period and a gate to each wave generator. It sits between the host/config logic and the wave-generator bank.

---
 rtl/chan_sequencer_if.sv | 37 +++
 rtl/chan_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/chan_sequencer_if.sv
// Host-to-sequencer bundle: pattern writes, transport controls, and per-voice playback outputs.
// Outputs are registered in the sequencer; no backpressure, the wave generators simply follow.
interface chan_sequencer_if #(
    parameter int NUM_STEPS = 16,
    parameter int PERIOD_W  = 32
);
    localparam int SW = $clog2(NUM_STEPS);

    logic                start;
    logic                stop;
    logic                loop_en;
    logic [15:0]         ticks_per_step;
    logic                wr_en;
    logic [SW-1:0]       wr_step;
    logic [1:0]          wr_chan;
    logic [PERIOD_W-1:0] wr_period;

    logic [PERIOD_W-1:0] period0;
    logic [PERIOD_W-1:0] period1;
    logic [PERIOD_W-1:0] period2;
    logic [PERIOD_W-1:0] period3;
    logic [3:0]          gate;
    logic [SW-1:0]       step_idx;
    logic                step_strobe;
    logic                running;
    logic                done;

    modport master (
        output start, stop, loop_en, ticks_per_step, wr_en, wr_step, wr_chan, wr_period,
        input  period0, period1, period2, period3, gate, step_idx, step_strobe, running, done
    );

    modport slave (
        input  start, stop, loop_en, ticks_per_step, wr_en, wr_step, wr_chan, wr_period,
        output period0, period1, period2, period3, gate, step_idx, step_strobe, running, done
    );
endinterface

// File: rtl/chan_sequencer.sv
// Four-voice step sequencer: each step = 1 LOAD cycle (gate gap) + eff_tps*TICK_DIV PLAY cycles.
// All outputs registered; no backpressure, stop aborts immediately and wins over start/step end.
module chan_sequencer #(
    parameter int NUM_STEPS = 16,
    parameter int TICK_DIV  = 50000,
    parameter int PERIOD_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    chan_sequencer_if.slave  seq_if
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] pat_q [NUM_STEPS][4];
    logic [PERIOD_W-1:0] per_q [4];
    logic [PERIOD_W-1:0] per_d [4];
    logic [3:0]          gate_q, gate_d;
    logic [SW-1:0]       idx_q, idx_d;
    logic                strobe_q, strobe_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic [15:0]         tps_q, tps_d;
    logic [15:0]         tick_q, tick_d;
    logic [PW-1:0]       presc_q, presc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STEPS; s++) begin
                for (int c = 0; c < 4; c++) begin
                    pat_q[s][c] <= '0;
                end
            end
        end else if (seq_if.wr_en) begin
            pat_q[seq_if.wr_step][seq_if.wr_chan] <= seq_if.wr_period;
        end
    end

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        gate_d   = gate_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        run_d    = run_q;
        done_d   = 1'b0;
        tps_d    = tps_q;
        tick_d   = tick_q;
        presc_d  = presc_q;

        case (state_q)
            S_IDLE: begin
                if (seq_if.start) begin
                    state_d = S_LOAD;
                    run_d   = 1'b1;
                end
            end
            S_LOAD: begin
                tps_d    = (seq_if.ticks_per_step == 16'd0) ? 16'd1 : seq_if.ticks_per_step;
                state_d  = S_PLAY;
                strobe_d = 1'b1;
                presc_d  = '0;
                tick_d   = '0;
                for (int c = 0; c < 4; c++) begin
                    per_d[c]  = pat_q[idx_q][c];
                    gate_d[c] = |pat_q[idx_q][c];
                end
            end
            S_PLAY: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (tick_q + 16'd1 == tps_q) begin
                        gate_d = '0;
                        if (idx_q != LAST_STEP || seq_if.loop_en) begin
                            // Power-of-two length lets the increment wrap to step 0 for free.
                            idx_d   = idx_q + 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            idx_d   = '0;
                            state_d = S_IDLE;
                            run_d   = 1'b0;
                            done_d  = 1'b1;
                            for (int c = 0; c < 4; c++) per_d[c] = '0;
                        end
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (seq_if.stop) begin
            state_d  = S_IDLE;
            gate_d   = '0;
            idx_d    = '0;
            strobe_d = 1'b0;
            run_d    = 1'b0;
            done_d   = 1'b0;
            for (int c = 0; c < 4; c++) per_d[c] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            for (int c = 0; c < 4; c++) per_q[c] <= '0;
            gate_q   <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            tps_q    <= 16'd1;
            tick_q   <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            gate_q   <= gate_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            run_q    <= run_d;
            done_q   <= done_d;
            tps_q    <= tps_d;
            tick_q   <= tick_d;
            presc_q  <= presc_d;
        end
    end

    assign seq_if.period0     = per_q[0];
    assign seq_if.period1     = per_q[1];
    assign seq_if.period2     = per_q[2];
    assign seq_if.period3     = per_q[3];
    assign seq_if.gate        = gate_q;
    assign seq_if.step_idx    = idx_q;
    assign seq_if.step_strobe = strobe_q;
    assign seq_if.running     = run_q;
    assign seq_if.done        = done_q;
endmodule
